// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu -- pak-rv memory stage (between EX and WB).
//
// Forwards the ALU result / rd / writeback controls to WB and runs loads and
// stores over a variable-latency req/gnt/rvalid data-memory port.
//   clk, arst_n          clock, asynchronous active-low reset
//   flush                kills the current or incoming op
//   in_valid/in_ready    EX handshake; in_ready drops while a transaction is open
//   in_*                 EX payload: result/address, store data, rd, wb controls,
//                        mem op (0 none, 1 load, 2 store, 3 none), size, unsigned
//   dmem_*               memory port: req/we/addr/wdata/be out, gnt/rvalid/rdata in
//   out_*                WB payload; out_valid is a one-cycle pulse per op,
//                        out_misalign flags a misaligned access (wb_en forced 0)

// One byte lane of the store-data replicator: lane LANE takes byte
// (LANE mod access_bytes) of the store data.
module mem_stage_lsu_lane #(
  parameter int XLEN = 32,
  parameter int LANE = 0
) (
  input  logic [XLEN-1:0] data,
  input  logic [1:0]      size,
  output logic [7:0]      lane_byte
);
  int idx;
  always_comb begin
    idx       = LANE & ((1 << size) - 1);
    lane_byte = 8'(data >> (8 * idx));
  end
endmodule

module mem_stage_lsu #(
  parameter  int XLEN   = 32,
  parameter  int REG_AW = 5,
  localparam int BE_W   = XLEN / 8
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_opr_res,
  input  logic [XLEN-1:0]   in_store_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_wb_en,
  input  logic [1:0]        in_wb_sel,
  input  logic [1:0]        in_mem_op,
  input  logic [1:0]        in_mem_size,
  input  logic              in_mem_uns,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [BE_W-1:0]   dmem_be,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              out_valid,
  output logic [XLEN-1:0]   out_opr_res,
  output logic [XLEN-1:0]   out_dmem_rdata,
  output logic [REG_AW-1:0] out_rd,
  output logic              out_wb_en,
  output logic [1:0]        out_wb_sel,
  output logic              out_misalign
);
  localparam int OFFW = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  // Op held while the memory transaction is in flight.
  typedef struct packed {
    logic [XLEN-1:0]   opr_res;
    logic [OFFW-1:0]   off;
    logic [1:0]        size;
    logic              uns;
    logic              we;
    logic [REG_AW-1:0] rd;
    logic              wb_en;
    logic [1:0]        wb_sel;
  } op_t;

  state_t state, state_n;
  op_t    op_q;
  logic [XLEN-1:0] addr_q, wdata_q;
  logic [BE_W-1:0] be_q;
  logic            kill_q;

  // ---------------- incoming op decode ----------------
  logic [OFFW-1:0] off_in;
  logic            is_mem, mis_raw, mis, accept, start_mem;
  logic [BE_W-1:0] be_base, be_in;
  logic [BE_W-1:0][7:0] wdata_lanes;

  assign off_in = in_opr_res[OFFW-1:0];
  assign is_mem = (in_mem_op == 2'd1) || (in_mem_op == 2'd2);

  always_comb begin
    mis_raw = 1'b0;
    be_base = '1;
    case (in_mem_size)
      2'd0: be_base = BE_W'(1);
      2'd1: begin mis_raw = off_in[0];      be_base = BE_W'(3);  end
      2'd2: begin mis_raw = |off_in[1:0];   be_base = BE_W'(15); end
      default: mis_raw = (XLEN == 32) ? 1'b1 : |off_in;
    endcase
  end

  assign mis       = is_mem & mis_raw;
  assign be_in     = be_base << off_in;
  assign accept    = in_valid & in_ready & ~flush;
  assign start_mem = accept & is_mem & ~mis;

  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    mem_stage_lsu_lane #(.XLEN(XLEN), .LANE(g)) u_lane (
      .data      (in_store_data),
      .size      (in_mem_size),
      .lane_byte (wdata_lanes[g])
    );
  end

  // Shift the addressed bytes down, then truncate and extend to the access size.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] d,
                                               input logic [OFFW-1:0] off,
                                               input logic [1:0]      sz,
                                               input logic            uns);
    logic [XLEN-1:0] t;
    int              sa;
    t  = d >> {off, 3'b000};
    sa = ((8 << sz) >= XLEN) ? 0 : XLEN - (8 << sz);
    t  = t << sa;
    if (uns) t = t >> sa;
    else     t = $signed(t) >>> sa;
    return t;
  endfunction

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:     if (start_mem) state_n = REQ;
      // A grant wins over a same-cycle flush: the transaction is already issued.
      REQ:      if (dmem_gnt)   state_n = op_q.we ? IDLE : WAIT_RSP;
                else if (flush) state_n = IDLE;
      WAIT_RSP: if (dmem_rvalid) state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready   = (state == IDLE);
    dmem_req   = (state == REQ);
    dmem_we    = dmem_req & op_q.we;
    dmem_addr  = addr_q;
    dmem_wdata = wdata_q;
    dmem_be    = be_q;
  end

  // ---------------- transaction latch / kill flag ----------------
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      kill_q  <= 1'b0;
    end else begin
      if (start_mem) begin
        op_q    <= '{opr_res: in_opr_res, off: off_in, size: in_mem_size,
                     uns: in_mem_uns, we: (in_mem_op == 2'd2), rd: in_rd,
                     wb_en: in_wb_en, wb_sel: in_wb_sel};
        addr_q  <= {in_opr_res[XLEN-1:OFFW], {OFFW{1'b0}}};
        wdata_q <= wdata_lanes;
        be_q    <= be_in;
        kill_q  <= 1'b0;
      end else if ((state == REQ && dmem_gnt && flush && !op_q.we) ||
                   (state == WAIT_RSP && flush)) begin
        kill_q  <= 1'b1;
      end
    end
  end

  // ---------------- WB payload ----------------
  // Payload holds between pulses; only out_valid and out_wb_en are cleared.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      out_valid      <= 1'b0;
      out_opr_res    <= '0;
      out_dmem_rdata <= '0;
      out_rd         <= '0;
      out_wb_en      <= 1'b0;
      out_wb_sel     <= '0;
      out_misalign   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      out_wb_en <= 1'b0;
      if (accept && !start_mem) begin
        // Non-memory op or misaligned access: completes without the port.
        out_valid      <= 1'b1;
        out_opr_res    <= in_opr_res;
        out_dmem_rdata <= '0;
        out_rd         <= in_rd;
        out_wb_en      <= in_wb_en & ~mis;
        out_wb_sel     <= in_wb_sel;
        out_misalign   <= mis;
      end else if (state == REQ && dmem_gnt && op_q.we && !flush) begin
        out_valid      <= 1'b1;
        out_opr_res    <= op_q.opr_res;
        out_dmem_rdata <= '0;
        out_rd         <= op_q.rd;
        out_wb_en      <= op_q.wb_en;
        out_wb_sel     <= op_q.wb_sel;
        out_misalign   <= 1'b0;
      end else if (state == WAIT_RSP && dmem_rvalid && !kill_q && !flush) begin
        out_valid      <= 1'b1;
        out_opr_res    <= op_q.opr_res;
        out_dmem_rdata <= load_ext(dmem_rdata, op_q.off, op_q.size, op_q.uns);
        out_rd         <= op_q.rd;
        out_wb_en      <= op_q.wb_en;
        out_wb_sel     <= op_q.wb_sel;
        out_misalign   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a vector table run through a small memory
// responder (XLEN=32), plus hand sequences for flush, reset and XLEN=64.
module tb_mem_stage_lsu;
  logic clk = 0, arst_n = 0, flush = 0;
  always #5 clk = ~clk;

  // ---------------- XLEN=32 instance ----------------
  logic        in_valid, in_ready, in_wb_en, in_mem_uns;
  logic [31:0] in_opr_res, in_store_data;
  logic [4:0]  in_rd;
  logic [1:0]  in_wb_sel, in_mem_op, in_mem_size;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        out_valid, out_wb_en, out_misalign;
  logic [31:0] out_opr_res, out_dmem_rdata;
  logic [4:0]  out_rd;
  logic [1:0]  out_wb_sel;

  mem_stage_lsu #(.XLEN(32), .REG_AW(5)) u32 (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_opr_res(in_opr_res),
    .in_store_data(in_store_data), .in_rd(in_rd), .in_wb_en(in_wb_en),
    .in_wb_sel(in_wb_sel), .in_mem_op(in_mem_op), .in_mem_size(in_mem_size),
    .in_mem_uns(in_mem_uns),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_opr_res(out_opr_res),
    .out_dmem_rdata(out_dmem_rdata), .out_rd(out_rd), .out_wb_en(out_wb_en),
    .out_wb_sel(out_wb_sel), .out_misalign(out_misalign)
  );

  // ---------------- XLEN=64 instance ----------------
  logic        v64, rdy64, req64, we64, gnt64, rv64, ov64, wb64, mis64;
  logic [63:0] res64, sd64, addr64, wd64, rd64, oopr64, ordata64;
  logic [1:0]  sz64, wbs64, owbs64;
  logic        uns64;
  logic [7:0]  be64;
  logic [4:0]  ord64;

  mem_stage_lsu #(.XLEN(64), .REG_AW(5)) u64 (
    .clk(clk), .arst_n(arst_n), .flush(flush),
    .in_valid(v64), .in_ready(rdy64), .in_opr_res(res64),
    .in_store_data(sd64), .in_rd(5'd3), .in_wb_en(1'b1),
    .in_wb_sel(wbs64), .in_mem_op(2'd1), .in_mem_size(sz64),
    .in_mem_uns(uns64),
    .dmem_req(req64), .dmem_we(we64), .dmem_addr(addr64),
    .dmem_wdata(wd64), .dmem_be(be64), .dmem_gnt(gnt64),
    .dmem_rvalid(rv64), .dmem_rdata(rd64),
    .out_valid(ov64), .out_opr_res(oopr64),
    .out_dmem_rdata(ordata64), .out_rd(ord64), .out_wb_en(wb64),
    .out_wb_sel(owbs64), .out_misalign(mis64)
  );

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
    else n_pass++;
  endtask

  typedef struct {
    logic [1:0]  op, sz;
    logic        uns, wb;
    logic [31:0] addr, sdata, rdata;
    int          gd, rd;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata, exp_rout;
    logic        exp_mis, exp_wb;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic        saw_req, stable, we, mis, wb, rdy_end;
    logic [31:0] addr, wdata, rout, opr;
    logic [3:0]  be;
    int          lat, ready_low;
  } res_t;

  // Issue one op and play memory: grant after gd request cycles, rvalid rd
  // cycles after the grant. Stops at out_valid or after 20 cycles.
  task automatic run_op(input vec_t v, output res_t r);
    int reqc = 0, gcyc = -1;
    bit done = 0;
    r = '{default: 0};
    in_valid = 1; in_mem_op = v.op; in_mem_size = v.sz; in_mem_uns = v.uns;
    in_wb_en = v.wb; in_rd = 5'd7; in_wb_sel = 2'd1;
    in_opr_res = v.addr; in_store_data = v.sdata;
    @(negedge clk);
    in_valid = 0;
    for (int cyc = 1; cyc <= 20 && !done; cyc++) begin
      dmem_gnt = 0; dmem_rvalid = 0;
      if (out_valid) begin
        done = 1; r.lat = cyc; r.rout = out_dmem_rdata; r.mis = out_misalign;
        r.wb = out_wb_en; r.opr = out_opr_res; r.rdy_end = in_ready;
        if (dmem_req) r.saw_req = 1;
      end else begin
        if (!in_ready) r.ready_low++;
        if (dmem_req) begin
          if (!r.saw_req) begin
            r.saw_req = 1; r.stable = 1; r.addr = dmem_addr; r.be = dmem_be;
            r.wdata = dmem_wdata; r.we = dmem_we;
          end else if (dmem_addr != r.addr || dmem_be != r.be ||
                       dmem_wdata != r.wdata || dmem_we != r.we) r.stable = 0;
          if (reqc == v.gd) begin dmem_gnt = 1; gcyc = cyc; end
          reqc++;
        end
        if (gcyc > 0 && cyc == gcyc + v.rd && !r.we) begin
          dmem_rvalid = 1; dmem_rdata = v.rdata;
        end
        @(negedge clk);
      end
    end
    dmem_gnt = 0; dmem_rvalid = 0;
  endtask

  // XLEN=64 load: immediate grant, rvalid one cycle later.
  task automatic run64(input logic [1:0] sz, input logic [63:0] addr, input logic [63:0] rdata,
                       output logic mis, output logic [63:0] a, output logic [7:0] be,
                       output logic [63:0] rout, output int lat);
    int gcyc = -1;
    bit done = 0;
    mis = 0; a = 0; be = 0; rout = 0; lat = 0;
    v64 = 1; sz64 = sz; res64 = addr; uns64 = 0;
    @(negedge clk);
    v64 = 0;
    for (int cyc = 1; cyc <= 10 && !done; cyc++) begin
      gnt64 = 0; rv64 = 0;
      if (ov64) begin
        done = 1; lat = cyc; mis = mis64; rout = ordata64;
      end else begin
        if (req64) begin a = addr64; be = be64; gnt64 = 1; gcyc = cyc; end
        if (gcyc > 0 && cyc == gcyc + 1) begin rv64 = 1; rd64 = rdata; end
        @(negedge clk);
      end
    end
    gnt64 = 0; rv64 = 0;
  endtask

  vec_t vecs[12];
  res_t r;
  int   ovs;
  logic        m;
  logic [63:0] a64, ro64;
  logic [7:0]  b64;
  int          l64;

  initial begin
    //           op    sz    uns   wb    addr          sdata         rdata         gd rd req  exp_addr      be     wdata         rout          mis   wb    lat
    vecs[0]  = '{2'd1, 2'd0, 1'b0, 1'b1, 32'h0000_1003, 32'h0,        32'h80FF_0000, 2, 1, 1'b1, 32'h0000_1000, 4'h8, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b1, 5};
    vecs[1]  = '{2'd2, 2'd1, 1'b0, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,        0, 1, 1'b1, 32'h0000_2000, 4'hC, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 2};
    vecs[2]  = '{2'd1, 2'd2, 1'b0, 1'b1, 32'h0000_3001, 32'h0,        32'h0,        0, 1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    vecs[3]  = '{2'd1, 2'd1, 1'b1, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_1234, 0, 1, 1'b1, 32'h0000_1000, 4'hC, 32'h0,        32'h0000_8001, 1'b0, 1'b1, 3};
    vecs[4]  = '{2'd1, 2'd1, 1'b0, 1'b1, 32'h0000_1002, 32'h0,        32'h8001_1234, 0, 1, 1'b1, 32'h0000_1000, 4'hC, 32'h0,        32'hFFFF_8001, 1'b0, 1'b1, 3};
    vecs[5]  = '{2'd2, 2'd0, 1'b0, 1'b0, 32'h0000_5001, 32'h1234_56A5, 32'h0,        0, 1, 1'b1, 32'h0000_5000, 4'h2, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 2};
    vecs[6]  = '{2'd2, 2'd2, 1'b0, 1'b0, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0,        1, 1, 1'b1, 32'h0000_6000, 4'hF, 32'hDEAD_BEEF, 32'h0,        1'b0, 1'b0, 3};
    vecs[7]  = '{2'd1, 2'd2, 1'b0, 1'b1, 32'h0000_7004, 32'h0,        32'hCAFE_F00D, 0, 3, 1'b1, 32'h0000_7004, 4'hF, 32'h0,        32'hCAFE_F00D, 1'b0, 1'b1, 5};
    vecs[8]  = '{2'd2, 2'd1, 1'b0, 1'b1, 32'h0000_2001, 32'h0000_1111, 32'h0,        0, 1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    vecs[9]  = '{2'd1, 2'd3, 1'b0, 1'b1, 32'h0000_8000, 32'h0,        32'h0,        0, 1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 1};
    vecs[10] = '{2'd1, 2'd0, 1'b1, 1'b1, 32'h0000_1001, 32'h0,        32'h0000_9C00, 0, 1, 1'b1, 32'h0000_1000, 4'h2, 32'h0,        32'h0000_009C, 1'b0, 1'b1, 3};
    vecs[11] = '{2'd3, 2'd2, 1'b0, 1'b1, 32'h0000_0055, 32'h0,        32'h0,        0, 1, 1'b0, 32'h0,        4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 1};

    in_valid = 0; in_opr_res = 0; in_store_data = 0; in_rd = 0; in_wb_en = 0;
    in_wb_sel = 0; in_mem_op = 0; in_mem_size = 0; in_mem_uns = 0;
    dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0;
    v64 = 0; res64 = 0; sd64 = 0; sz64 = 0; uns64 = 0; wbs64 = 0;
    gnt64 = 0; rv64 = 0; rd64 = 0;
    repeat (2) @(negedge clk);
    arst_n = 1;

    // ---- reset state ----
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    chk("rst dmem_req", dmem_req, 0);
    chk("rst dmem_be", dmem_be, 0);
    chk("rst dmem_addr", dmem_addr, 0);
    chk("rst out_opr_res", out_opr_res, 0);

    // ---- back-to-back passthrough ----
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_mem_op = 0; in_mem_size = 0; in_wb_en = 1; in_wb_sel = 0;
      in_opr_res = 32'(16 * (i + 1)); in_rd = 5'(i + 1);
      @(negedge clk);
      chk($sformatf("pt%0d out_valid", i), out_valid, 1);
      chk($sformatf("pt%0d opr_res", i), out_opr_res, 64'(16 * (i + 1)));
      chk($sformatf("pt%0d rd", i), out_rd, 64'(i + 1));
      chk($sformatf("pt%0d in_ready", i), in_ready, 1);
    end
    in_valid = 0;
    @(negedge clk);
    chk("pt idle out_valid", out_valid, 0);
    chk("pt idle wb_en", out_wb_en, 0);
    chk("pt hold opr_res", out_opr_res, 32'h30);

    // ---- vector table ----
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i], r);
      chk($sformatf("v%0d lat", i), r.lat, vecs[i].exp_lat);
      chk($sformatf("v%0d ready_low", i), r.ready_low, vecs[i].exp_lat - 1);
      chk($sformatf("v%0d ready_end", i), r.rdy_end, 1);
      chk($sformatf("v%0d req", i), r.saw_req, vecs[i].exp_req);
      chk($sformatf("v%0d misalign", i), r.mis, vecs[i].exp_mis);
      chk($sformatf("v%0d wb_en", i), r.wb, vecs[i].exp_wb);
      chk($sformatf("v%0d rdata", i), r.rout, vecs[i].exp_rout);
      chk($sformatf("v%0d opr_res", i), r.opr, vecs[i].addr);
      if (vecs[i].exp_req) begin
        chk($sformatf("v%0d addr", i), r.addr, vecs[i].exp_addr);
        chk($sformatf("v%0d be", i), r.be, vecs[i].exp_be);
        chk($sformatf("v%0d we", i), r.we, vecs[i].op == 2'd2);
        chk($sformatf("v%0d stable", i), r.stable, 1);
        if (vecs[i].op == 2'd2) chk($sformatf("v%0d wdata", i), r.wdata, vecs[i].exp_wdata);
      end
      @(negedge clk);
    end

    // ---- flush in WAIT_RSP, rvalid 4 cycles later ----
    in_valid = 1; in_mem_op = 1; in_mem_size = 2; in_opr_res = 32'h100; in_wb_en = 1;
    @(negedge clk); in_valid = 0;
    chk("fw req", dmem_req, 1);
    dmem_gnt = 1;
    @(negedge clk); dmem_gnt = 0;
    chk("fw ready", in_ready, 0);
    flush = 1; ovs = 0;
    @(negedge clk); flush = 0;
    for (int i = 0; i < 3; i++) begin ovs += out_valid; @(negedge clk); end
    ovs += out_valid;
    dmem_rvalid = 1; dmem_rdata = 32'h1234_5678;
    @(negedge clk); dmem_rvalid = 0;
    ovs += out_valid;
    chk("fw no out_valid", ovs, 0);
    chk("fw back idle", in_ready, 1);
    in_valid = 1; in_mem_op = 0; in_opr_res = 32'h77;
    @(negedge clk); in_valid = 0;
    chk("fw next valid", out_valid, 1);
    chk("fw next opr", out_opr_res, 32'h77);

    // ---- flush in REQ before gnt ----
    in_valid = 1; in_mem_op = 2; in_mem_size = 2; in_opr_res = 32'h200;
    @(negedge clk); in_valid = 0;
    chk("fr req", dmem_req, 1);
    flush = 1;
    @(negedge clk); flush = 0;
    chk("fr req dropped", dmem_req, 0);
    chk("fr ready", in_ready, 1);
    chk("fr out_valid", out_valid, 0);
    @(negedge clk);
    chk("fr out_valid2", out_valid, 0);

    // ---- flush with gnt on a load: issued then killed ----
    in_valid = 1; in_mem_op = 1; in_mem_size = 2; in_opr_res = 32'h204;
    @(negedge clk); in_valid = 0;
    dmem_gnt = 1; flush = 1;
    @(negedge clk); dmem_gnt = 0; flush = 0;
    chk("fg wait_rsp", in_ready, 0);
    dmem_rvalid = 1;
    @(negedge clk); dmem_rvalid = 0;
    chk("fg out_valid", out_valid, 0);
    chk("fg idle", in_ready, 1);

    // ---- flush in IDLE blocks accept ----
    in_valid = 1; in_mem_op = 0; in_opr_res = 32'h99; flush = 1;
    @(negedge clk); in_valid = 0; flush = 0;
    chk("fi out_valid", out_valid, 0);

    // ---- reset mid-transaction, late rvalid ignored ----
    in_valid = 1; in_mem_op = 1; in_mem_size = 2; in_opr_res = 32'h300;
    @(negedge clk); in_valid = 0;
    chk("rm req", dmem_req, 1);
    arst_n = 0;
    #1;
    chk("rm req async", dmem_req, 0);
    chk("rm ready", in_ready, 1);
    @(negedge clk); arst_n = 1; dmem_rvalid = 1;
    @(negedge clk); dmem_rvalid = 0;
    chk("rm late rvalid", out_valid, 0);
    chk("rm no req", dmem_req, 0);

    // ---- XLEN=64 ----
    run64(2'd3, 64'h4008, 64'h8000_0000_0000_0001, m, a64, b64, ro64, l64);
    chk("x64 dbl lat", l64, 3);
    chk("x64 dbl mis", m, 0);
    chk("x64 dbl addr", a64, 64'h4008);
    chk("x64 dbl be", b64, 8'hFF);
    chk("x64 dbl data", ro64, 64'h8000_0000_0000_0001);
    @(negedge clk);
    run64(2'd3, 64'h4004, 64'h0, m, a64, b64, ro64, l64);
    chk("x64 dbl mis lat", l64, 1);
    chk("x64 dbl misalign", m, 1);
    @(negedge clk);
    run64(2'd2, 64'h4004, 64'h8000_0000_1234_5678, m, a64, b64, ro64, l64);
    chk("x64 word lat", l64, 3);
    chk("x64 word addr", a64, 64'h4000);
    chk("x64 word be", b64, 8'hF0);
    chk("x64 word data", ro64, 64'hFFFF_FFFF_8000_0000);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
